// File: rtl/x86_pkg.sv
// Shared x86 encoding definitions: field tags, legacy prefix bytes, REX/escape
// constants, plus the encoder's FSM state and registered request types.
package x86_pkg;

  typedef enum logic [2:0] {
    UNDEFINED     = 3'd0,
    LEGACY_PREFIX = 3'd1,
    REX_PREFIX    = 3'd2,
    OPCODE        = 3'd3,
    MOD_RM        = 3'd4,
    SIB           = 3'd5,
    DISPLACEMENT  = 3'd6,
    IMMEDIATE     = 3'd7
  } inst_field_t;

  localparam logic [7:0] PFX_LOCK   = 8'hF0;
  localparam logic [7:0] PFX_REPNE  = 8'hF2;
  localparam logic [7:0] PFX_REP    = 8'hF3;
  localparam logic [7:0] PFX_CS     = 8'h2E;
  localparam logic [7:0] PFX_SS     = 8'h36;
  localparam logic [7:0] PFX_DS     = 8'h3E;
  localparam logic [7:0] PFX_ES     = 8'h26;
  localparam logic [7:0] PFX_FS     = 8'h64;
  localparam logic [7:0] PFX_GS     = 8'h65;
  localparam logic [7:0] PFX_OPSIZE = 8'h66;
  localparam logic [7:0] PFX_ADSIZE = 8'h67;

  localparam logic [3:0] REX_ID       = 4'b0100;
  localparam logic [7:0] ESC_0F       = 8'h0F;
  localparam int         MAX_INST_LEN = 15;

  // State order is emission order; the encoder relies on it to find the next field.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_PFX   = 4'd1,
    ST_REX   = 4'd2,
    ST_ESC   = 4'd3,
    ST_OPC   = 4'd4,
    ST_MODRM = 4'd5,
    ST_SIB   = 4'd6,
    ST_DISP  = 4'd7,
    ST_IMM   = 4'd8
  } enc_state_t;

  typedef struct packed {
    logic        pfx_en;
    logic [7:0]  pfx;
    logic        rex_en;
    logic [3:0]  rex_wrxb;
    logic        esc_en;
    logic [7:0]  opcode;
    logic        modrm_en;
    logic [7:0]  modrm;
    logic        sib_en;
    logic [7:0]  sib;
    logic [2:0]  disp_len;
    logic [31:0] disp;
    logic [3:0]  imm_len;
    logic [63:0] imm;
  } enc_req_t;

endpackage

// File: rtl/inst_encoder_if.sv
// Request and byte-stream signals of the x86 instruction encoder.
interface inst_encoder_if;
  // valid/ready: a transfer happens on a rising clk edge where valid && ready;
  // the source holds its payload stable while valid=1 and ready=0.
  logic        in_valid;
  logic        in_ready;
  logic        pfx_en;
  logic [7:0]  pfx;
  logic        rex_en;
  logic [3:0]  rex_wrxb;
  logic        esc_en;
  logic [7:0]  opcode;
  logic        modrm_en;
  logic [7:0]  modrm;
  logic        sib_en;
  logic [7:0]  sib;
  logic [2:0]  disp_len;
  logic [31:0] disp;
  logic [3:0]  imm_len;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [3:0]  inst_len;
  logic        err;

  modport master (
    output in_valid, pfx_en, pfx, rex_en, rex_wrxb, esc_en, opcode, modrm_en, modrm,
           sib_en, sib, disp_len, disp, imm_len, imm, out_ready,
    input  in_ready, out_valid, out_byte, out_last, inst_len, err
  );

  modport slave (
    input  in_valid, pfx_en, pfx, rex_en, rex_wrxb, esc_en, opcode, modrm_en, modrm,
           sib_en, sib, disp_len, disp, imm_len, imm, out_ready,
    output in_ready, out_valid, out_byte, out_last, inst_len, err
  );
endinterface

// File: rtl/inst_enc_len.sv
// Instruction length and legality. Legality checks exist only when
// INST_ENC_CHECK_EN is defined; otherwise nothing is rejected.
module inst_enc_len
  import x86_pkg::*;
#(
  parameter int MAX_LEN = MAX_INST_LEN
) (
  input  logic       pfx_en,
  input  logic       rex_en,
  input  logic       esc_en,
  input  logic       modrm_en,
  input  logic       sib_en,
  input  logic [7:0] modrm,
  input  logic [2:0] disp_len,
  input  logic [3:0] imm_len,
  output logic [3:0] len,
  output logic       reject
);
  logic [4:0] full_len;
  logic       unused_ok;

  assign full_len = {4'd0, pfx_en} + {4'd0, rex_en} + {4'd0, esc_en} + 5'd1
                  + {4'd0, modrm_en} + {4'd0, sib_en} + {2'd0, disp_len} + {1'd0, imm_len};
  assign len = full_len[3:0];

`ifdef INST_ENC_CHECK_EN
  logic sib_bad;
  logic len_bad;
  // A SIB byte only exists behind a memory-form ModRM with rm=100.
  assign sib_bad = sib_en && (!modrm_en || (modrm[2:0] != 3'b100) || (modrm[7:6] == 2'b11));
  assign len_bad = !(disp_len inside {3'd0, 3'd1, 3'd4})
                || !(imm_len inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8})
                || (int'(full_len) > MAX_LEN);
  assign reject    = sib_bad || len_bad;
  assign unused_ok = ^modrm[5:3];
`else
  assign reject    = 1'b0;
  assign unused_ok = ^{modrm, full_len[4]};
`endif
endmodule

// File: rtl/inst_encoder.sv
// x86 instruction encoder: accepts one field-level request and streams its
// bytes one per handshake. Request checking is enabled by INST_ENC_CHECK_EN.
module inst_encoder
  import x86_pkg::*;
#(
  parameter int MAX_LEN = MAX_INST_LEN
) (
  input  logic          clk,
  input  logic          reset,
  inst_encoder_if.slave bus,
  output enc_state_t    dbg_state,
  output inst_field_t   dbg_field
);
  enc_state_t state, state_d, nxt_field;
  enc_req_t   req_in, req_q;
  logic [3:0] cnt, cnt_d, len_in, len_q;
  logic [8:0] pres_in, pres_q;
  logic [7:0] byte_mux;
  logic       reject, accept, hs, ready_q, err_q, last_in_field, out_last;

  // Bit i set means state i has a byte to emit for this request.
  function automatic logic [8:0] presence(enc_req_t r);
    return {r.imm_len != 4'd0, r.disp_len != 3'd0, r.sib_en, r.modrm_en, 1'b1,
            r.esc_en, r.rex_en, r.pfx_en, 1'b0};
  endfunction

  function automatic enc_state_t next_present(enc_state_t s, logic [8:0] pres);
    enc_state_t n;
    n = ST_IDLE;
    for (int i = 8; i >= 0; i--)
      if (pres[i] && (4'(i) > s)) n = enc_state_t'(4'(i));
    return n;
  endfunction

  assign req_in = '{pfx_en: bus.pfx_en, pfx: bus.pfx, rex_en: bus.rex_en, rex_wrxb: bus.rex_wrxb,
                    esc_en: bus.esc_en, opcode: bus.opcode, modrm_en: bus.modrm_en,
                    modrm: bus.modrm, sib_en: bus.sib_en, sib: bus.sib, disp_len: bus.disp_len,
                    disp: bus.disp, imm_len: bus.imm_len, imm: bus.imm};

  inst_enc_len #(.MAX_LEN(MAX_LEN)) u_len (
    .pfx_en(req_in.pfx_en), .rex_en(req_in.rex_en), .esc_en(req_in.esc_en),
    .modrm_en(req_in.modrm_en), .sib_en(req_in.sib_en), .modrm(req_in.modrm),
    .disp_len(req_in.disp_len), .imm_len(req_in.imm_len), .len(len_in), .reject(reject)
  );

  assign accept    = bus.in_valid && bus.in_ready;
  assign hs        = bus.out_valid && bus.out_ready;
  assign pres_in   = presence(req_in);
  assign pres_q    = presence(req_q);
  assign nxt_field = next_present(state, pres_q);

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    last_in_field = 1'b1;
    byte_mux      = 8'h00;
    dbg_field     = UNDEFINED;
    case (state)
      ST_PFX:   begin byte_mux = req_q.pfx;                  dbg_field = LEGACY_PREFIX; end
      ST_REX:   begin byte_mux = {REX_ID, req_q.rex_wrxb};   dbg_field = REX_PREFIX;    end
      ST_ESC:   begin byte_mux = ESC_0F;                     dbg_field = OPCODE;        end
      ST_OPC:   begin byte_mux = req_q.opcode;               dbg_field = OPCODE;        end
      ST_MODRM: begin byte_mux = req_q.modrm;                dbg_field = MOD_RM;        end
      ST_SIB:   begin byte_mux = req_q.sib;                  dbg_field = SIB;           end
      ST_DISP: begin
        byte_mux      = req_q.disp[{cnt[1:0], 3'b000} +: 8];
        last_in_field = (cnt == ({1'b0, req_q.disp_len} - 4'd1));
        dbg_field     = DISPLACEMENT;
      end
      ST_IMM: begin
        byte_mux      = req_q.imm[{cnt[2:0], 3'b000} +: 8];
        last_in_field = (cnt == (req_q.imm_len - 4'd1));
        dbg_field     = IMMEDIATE;
      end
      default: ;
    endcase
    out_last = (state != ST_IDLE) && last_in_field && (nxt_field == ST_IDLE);

    if (state == ST_IDLE) begin
      if (accept && !reject) begin
        state_d = next_present(ST_IDLE, pres_in);
        cnt_d   = '0;
      end
    end else if (hs) begin
      if (last_in_field) begin
        state_d = nxt_field;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      req_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ready_q <= 1'b1;
      err_q   <= accept && reject;
      if (accept && !reject) begin
        req_q <= req_in;
        len_q <= len_in;
      end
    end
  end

  assign bus.in_ready  = (state == ST_IDLE) && ready_q;
  assign bus.out_valid = (state != ST_IDLE);
  assign bus.out_byte  = byte_mux;
  assign bus.out_last  = out_last;
  assign bus.inst_len  = len_q;
  assign bus.err       = err_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (default and INST_ENC_CHECK_EN builds).
module tb_inst_encoder;
  import x86_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  enc_state_t  dbg_state;
  inst_field_t dbg_field;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic        got_last_q[$];
  logic [3:0]  got_len_q[$];
  int          stalls, stall_viol;
  bit          coll_done, err_seen;

  inst_encoder_if bus ();

  inst_encoder #(.MAX_LEN(15)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state), .dbg_field(dbg_field)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic set_fields(input enc_req_t r);
    bus.pfx_en = r.pfx_en;     bus.pfx = r.pfx;
    bus.rex_en = r.rex_en;     bus.rex_wrxb = r.rex_wrxb;
    bus.esc_en = r.esc_en;     bus.opcode = r.opcode;
    bus.modrm_en = r.modrm_en; bus.modrm = r.modrm;
    bus.sib_en = r.sib_en;     bus.sib = r.sib;
    bus.disp_len = r.disp_len; bus.disp = r.disp;
    bus.imm_len = r.imm_len;   bus.imm = r.imm;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic drive_req(input enc_req_t r);
    bit acc = 1'b0;
    set_fields(r);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20 && !acc; c++) begin
      if (bus.in_ready === 1'b1) acc = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL accept: in_ready never rose within 20 cycles"); end
  endtask

  // Drains one instruction; toggle=1 alternates out_ready 1/0 and audits stalls.
  task automatic collect(input bit toggle);
    logic [7:0] snap_b;
    logic       snap_l;
    logic [3:0] snap_len;
    bit         have_snap = 1'b0;
    got_q.delete(); got_last_q.delete(); got_len_q.delete();
    stalls = 0; stall_viol = 0; coll_done = 1'b0; err_seen = 1'b0;
    for (int c = 0; c < 60 && !coll_done; c++) begin
      if (have_snap) begin
        if (bus.out_byte !== snap_b || bus.out_last !== snap_l || bus.inst_len !== snap_len)
          stall_viol++;
        have_snap = 1'b0;
      end
      if (bus.err === 1'b1) err_seen = 1'b1;
      bus.out_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          got_q.push_back(bus.out_byte);
          got_last_q.push_back(bus.out_last);
          got_len_q.push_back(bus.inst_len);
          if (bus.out_last === 1'b1) coll_done = 1'b1;
        end else begin
          stalls++;
          snap_b = bus.out_byte; snap_l = bus.out_last; snap_len = bus.inst_len;
          have_snap = 1'b1;
        end
      end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 7;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    if (bus.out_byte !== 8'h00) begin errors++; $display("FAIL reset_out_byte: got %h want 00", bus.out_byte); end
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    if (bus.inst_len !== 4'd0) begin errors++; $display("FAIL reset_inst_len: got %0d want 0", bus.inst_len); end
    if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    if (dbg_state !== ST_IDLE || dbg_field !== UNDEFINED) begin
      errors++; $display("FAIL reset_state: got %0d/%0d want 0/0", dbg_state, dbg_field);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready: got %b want 0 before first edge", bus.in_ready); end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_rex_modrm();
    enc_req_t r = '0;
    r.rex_en = 1'b1; r.rex_wrxb = 4'h8; r.opcode = 8'h01; r.modrm_en = 1'b1; r.modrm = 8'hD8;
    exp_q = '{8'h48, 8'h01, 8'hD8};
    drive_req(r);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rex_latency: out_valid=%b want 1", bus.out_valid); end
    collect(1'b0);
    checks++;
    if (!coll_done || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rex_count: got %0d bytes done=%b, want %0d", got_q.size(), coll_done, exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1) || got_len_q[i] !== 4'd3) begin
        errors++; $display("FAIL rex_byte%0d: got %h last=%b len=%0d, want %h last=%b len=3",
                           i, got_q[i], got_last_q[i], got_len_q[i], exp_q[i], i == exp_q.size() - 1);
      end
    end
  endtask

  task automatic test_stall();
    enc_req_t r = '0;
    r.pfx_en = 1'b1; r.pfx = PFX_OPSIZE; r.esc_en = 1'b1; r.opcode = 8'hAF;
    r.modrm_en = 1'b1; r.modrm = 8'hC3;
    exp_q = '{8'h66, 8'h0F, 8'hAF, 8'hC3};
    drive_req(r);
    collect(1'b1);
    checks += 3;
    if (!coll_done || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_count: got %0d bytes done=%b, want %0d", got_q.size(), coll_done, exp_q.size());
    end
    if (stalls != 3) begin errors++; $display("FAIL stall_cycles: got %0d want 3", stalls); end
    if (stall_viol != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_viol); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1) || got_len_q[i] !== 4'd4) begin
        errors++; $display("FAIL stall_byte%0d: got %h last=%b len=%0d, want %h last=%b len=4",
                           i, got_q[i], got_last_q[i], got_len_q[i], exp_q[i], i == exp_q.size() - 1);
      end
    end
  endtask

  task automatic test_sib_disp();
    enc_req_t r = '0;
    r.opcode = 8'h8B; r.modrm_en = 1'b1; r.modrm = 8'h44; r.sib_en = 1'b1; r.sib = 8'h24;
    r.disp_len = 3'd1; r.disp = 32'h0000_0008;
    exp_q = '{8'h8B, 8'h44, 8'h24, 8'h08};
    drive_req(r);
    collect(1'b0);
    checks++;
    if (!coll_done || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sib_count: got %0d bytes done=%b, want %0d", got_q.size(), coll_done, exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1) || got_len_q[i] !== 4'd4) begin
        errors++; $display("FAIL sib_byte%0d: got %h last=%b len=%0d, want %h last=%b len=4",
                           i, got_q[i], got_last_q[i], got_len_q[i], exp_q[i], i == exp_q.size() - 1);
      end
    end
  endtask

  function automatic enc_req_t imm64_req();
    enc_req_t r = '0;
    r.rex_en = 1'b1; r.rex_wrxb = 4'h8; r.opcode = 8'hB8;
    r.imm_len = 4'd8; r.imm = 64'h1122_3344_5566_7788;
    return r;
  endfunction

  task automatic test_imm64();
    exp_q = '{8'h48, 8'hB8, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    drive_req(imm64_req());
    collect(1'b0);
    checks++;
    if (!coll_done || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL imm_count: got %0d bytes done=%b, want %0d", got_q.size(), coll_done, exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1) || got_len_q[i] !== 4'd10) begin
        errors++; $display("FAIL imm_byte%0d: got %h last=%b len=%0d, want %h last=%b len=10",
                           i, got_q[i], got_last_q[i], got_len_q[i], exp_q[i], i == exp_q.size() - 1);
      end
    end
  endtask

  task automatic test_reject();
    enc_req_t r18 = '0;
    enc_req_t rc4 = '0;
    r18.pfx_en = 1'b1; r18.pfx = PFX_OPSIZE; r18.rex_en = 1'b1; r18.rex_wrxb = 4'h8;
    r18.esc_en = 1'b1; r18.opcode = 8'h69; r18.modrm_en = 1'b1; r18.modrm = 8'h44;
    r18.sib_en = 1'b1; r18.sib = 8'h24; r18.disp_len = 3'd4; r18.disp = 32'h1122_3344;
    r18.imm_len = 4'd8; r18.imm = 64'h0102_0304_0506_0708;
    rc4.opcode = 8'h8B; rc4.modrm_en = 1'b1; rc4.modrm = 8'hC4; rc4.sib_en = 1'b1; rc4.sib = 8'h24;
`ifdef INST_ENC_CHECK_EN
    begin
      int vcount = 0;
      drive_req(r18);
      checks += 3;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL rej18_err: got %b want 1", bus.err); end
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rej18_valid: got %b want 0", bus.out_valid); end
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rej18_idle: in_ready=%b want 1", bus.in_ready); end
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL rej18_pulse: err=%b want 0 one cycle later", bus.err); end
      for (int c = 0; c < 4; c++) begin
        if (bus.out_valid === 1'b1) vcount++;
        @(negedge clk);
      end
      checks++;
      if (vcount != 0) begin errors++; $display("FAIL rej18_bytes: got %0d valid cycles want 0", vcount); end
      drive_req(rc4);
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL rejc4_err: got %b want 1", bus.err); end
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL rejc4_after: err=%b out_valid=%b want 0/0", bus.err, bus.out_valid);
      end
    end
`else
    exp_q = '{8'h66, 8'h48, 8'h0F, 8'h69, 8'h44, 8'h24, 8'h44, 8'h33, 8'h22,
              8'h11, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    drive_req(r18);
    collect(1'b0);
    checks += 2;
    if (!coll_done || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL long_count: got %0d bytes done=%b, want %0d", got_q.size(), coll_done, exp_q.size());
    end
    if (err_seen) begin errors++; $display("FAIL long_err: err seen 1 want 0"); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1) || got_len_q[i] !== 4'd2) begin
        errors++; $display("FAIL long_byte%0d: got %h last=%b len=%0d, want %h last=%b len=2",
                           i, got_q[i], got_last_q[i], got_len_q[i], exp_q[i], i == exp_q.size() - 1);
      end
    end
    exp_q = '{8'h8B, 8'hC4, 8'h24};
    drive_req(rc4);
    collect(1'b0);
    checks++;
    if (!coll_done || got_q.size() != 3 || err_seen) begin
      errors++; $display("FAIL c4_count: got %0d bytes done=%b err=%b, want 3 bytes err=0", got_q.size(), coll_done, err_seen);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_len_q[i] !== 4'd3) begin
        errors++; $display("FAIL c4_byte%0d: got %h len=%0d, want %h len=3", i, got_q[i], got_len_q[i], exp_q[i]);
      end
    end
`endif
  endtask

  task automatic test_back_to_back();
    enc_req_t r = '0;
    enc_req_t nop = '0;
    r.opcode = 8'hC7; r.modrm_en = 1'b1; r.modrm = 8'h80; r.disp_len = 3'd4; r.disp = 32'h0000_0010;
    r.imm_len = 4'd2; r.imm = 64'h0000_0000_0000_BEEF;
    nop.opcode = 8'h90;
    exp_q = '{8'hC7, 8'h80, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE};
    drive_req(r);
    collect(1'b0);
    checks++;
    if (!coll_done || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d bytes done=%b, want %0d", got_q.size(), coll_done, exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1) || got_len_q[i] !== 4'd8) begin
        errors++; $display("FAIL b2b_byte%0d: got %h last=%b len=%0d, want %h last=%b len=8",
                           i, got_q[i], got_last_q[i], got_len_q[i], exp_q[i], i == exp_q.size() - 1);
      end
    end
    drive_req(nop);
    collect(1'b0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h90 || got_last_q[0] !== 1'b1 || got_len_q[0] !== 4'd1) begin
      errors++; $display("FAIL b2b_single: got %0d bytes first=%h last=%b len=%0d, want 1 byte 90 last=1 len=1",
                         got_q.size(), got_q[0], got_last_q[0], got_len_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    enc_req_t r = '0;
    drive_req(imm64_req());
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dbg_field !== IMMEDIATE || bus.out_byte !== 8'h88) begin
      errors++; $display("FAIL mid_pos: field=%0d byte=%h want 7/88", dbg_field, bus.out_byte);
    end
    #2 reset = 1'b0;
    #1;
    checks += 2;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_byte !== 8'h00) begin
      errors++; $display("FAIL mid_outputs: valid=%b last=%b byte=%h want 0/0/00", bus.out_valid, bus.out_last, bus.out_byte);
    end
    if (bus.inst_len !== 4'd0 || bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_status: len=%0d err=%b in_ready=%b want 0/0/0", bus.inst_len, bus.err, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    r.rex_en = 1'b1; r.rex_wrxb = 4'h8; r.opcode = 8'h01; r.modrm_en = 1'b1; r.modrm = 8'hD8;
    exp_q = '{8'h48, 8'h01, 8'hD8};
    drive_req(r);
    collect(1'b0);
    checks++;
    if (!coll_done || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL mid_next_count: got %0d bytes done=%b, want 3", got_q.size(), coll_done);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_len_q[i] !== 4'd3) begin
        errors++; $display("FAIL mid_next_byte%0d: got %h len=%0d, want %h len=3", i, got_q[i], got_len_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_fields('0);
    test_reset();
    test_rex_modrm();
    test_stall();
    test_sib_disp();
    test_imm64();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 15, meaning the maximum legal instruction length in bytes.
REQ-002 SHALL have port clk, input, 1, the single clock for all state.
REQ-003 SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-004 SHALL have in_valid, input, 1, and in_ready, output, 1, forming the request handshake.
REQ-005 SHALL have pfx_en, input, 1, and pfx, input, 8, for one legacy prefix byte (F0/F2/F3/2E/36/3E/26/64/65/66/67).
REQ-006 SHALL have rex_en, input, 1, and rex_wrxb, input, 4, the REX W/R/X/B bits.
REQ-007 SHALL have esc_en, input, 1, selecting the 0F two-byte opcode escape.
REQ-008 SHALL have opcode, input, 8.
REQ-009 SHALL have modrm_en, input, 1, and modrm, input, 8.
REQ-010 SHALL have sib_en, input, 1, and sib, input, 8.
REQ-011 SHALL have disp_len, input, 3 (legal values 0/1/4), and disp, input, 32.
REQ-012 SHALL have imm_len, input, 4 (legal values 0/1/2/4/8), and imm, input, 64.
REQ-013 SHALL have out_valid, output, 1, out_ready, input, 1, out_byte, output, 8, and out_last, output, 1.
REQ-014 SHALL have inst_len, output, 4, the total byte count of the instruction being emitted; it matches the decoder's byte increment.
REQ-015 SHALL have err, output, 1, a one-cycle pulse flagging a rejected request.

Function
REQ-016 SHALL have in_ready=1 only in state IDLE; a request is accepted on in_valid&in_ready, and all fields are registered at acceptance.
REQ-017 SHALL step through states IDLE->PFX->REX->ESC->OPC->MODRM->SIB->DISP->IMM->IDLE, skipping any state whose field is absent; OPC is always visited.
REQ-018 SHALL emit exactly one byte per out_valid&out_ready handshake, in this order: pfx, {4'b0100,rex_wrxb}, 8'h0F, opcode, modrm, sib, disp bytes LSB-first, imm bytes LSB-first.
REQ-019 SHALL assert out_valid on the cycle after acceptance; the first byte therefore has a latency of 1 cycle.
REQ-020 SHALL hold out_byte, out_last and inst_len stable while out_valid=1 and out_ready=0.
REQ-021 SHALL assert out_last only with the final byte; the FSM returns to IDLE on that handshake, so throughput is inst_len+1 cycles per instruction.
REQ-022 SHALL compute inst_len = pfx_en+rex_en+esc_en+1+modrm_en+sib_en+disp_len+imm_len and hold it valid during all out_valid cycles.
REQ-023 SHALL run a byte counter for DISP/IMM that counts 0..len-1 and resets at each state change.
REQ-024 SHALL reject a request when the check feature is on and any of the following holds: sib_en with !modrm_en; sib_en with modrm[2:0]!=3'b100; sib_en with modrm[7:6]==2'b11; an illegal disp_len/imm_len; or computed length >MAX_LEN (e.g. 18).
REQ-025 SHALL handle a rejected request as follows: consume it, pulse err on the following cycle, emit no bytes, and stay in IDLE.

Reset
REQ-026 SHALL, on reset low, asynchronously force state=IDLE, counter=0, and out_valid=0, out_last=0, out_byte=8'h00, inst_len=0, err=0, in_ready=0; in_ready rises on the first clk edge after release.
REQ-027 SHALL, on reset mid-instruction, discard the partial instruction; no further bytes of it are emitted after release.

Configuration
REQ-028 SHALL provide macro INST_ENC_CHECK_EN: when defined, REQ-024/025 checks are active; when undefined, err is tied 0, no checks are made, and bytes are emitted as given (length computed modulo 16).

Structure
REQ-029 SHALL place in shared package x86_pkg: the inst_field_t enum (UNDEFINED=0, LEGACY_PREFIX=1, REX_PREFIX=2, OPCODE=3, MOD_RM=4, SIB=5, DISPLACEMENT=6, IMMEDIATE=7), the legacy prefix constants, REX_ID=4'b0100, ESC_0F=8'h0F and MAX_INST_LEN=15.
REQ-030 SHALL implement the length/legality computation in combinational sub-module inst_enc_len, instantiated once.

Verification
REQ-031 SHALL cover: rex_en, rex_wrxb=8, opcode=01, modrm=D8 -> bytes 48 01 D8, inst_len=3, out_last on D8.
REQ-032 SHALL cover: pfx=66, esc_en, opcode=AF, modrm=C3, out_ready toggling 1/0 -> bytes 66 0F AF C3, each held stable while stalled, inst_len=4.
REQ-033 SHALL cover: opcode=8B, modrm=44, sib=24, disp_len=1, disp=08 -> bytes 8B 44 24 08.
REQ-034 SHALL cover: rex 48, opcode=B8, imm_len=8, imm=0x1122334455667788 -> bytes 48 B8 88 77 66 55 44 33 22 11, inst_len=10.
REQ-035 SHALL cover: all fields on, disp_len=4, imm_len=8 (length 18) -> err pulse 1 cycle, zero bytes emitted; sib_en with modrm=C4 -> err.
REQ-036 SHALL cover: reset low after the 2nd byte of the REQ-034 case -> outputs zero immediately; after release, the next request emits only its own bytes.
